mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage initiator for the byte-wide big-endian data memory. Takes lb/lbu/lh/lhu/lw/sb/sh/sw
//  requests from the pipeline, breaks each into sequential single-byte transfers over a
//  req/ack port, and assembles and extends load data. Holds Stall_M until the access completes.
// PARAMETERS
//  ADDR_W  10  byte-address width of the memory port (1024 bytes)
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       asynchronous active-low reset
//  Mem_Read_M      in   1       load request
//  Mem_Write_M     in   1       store request; wins if asserted together with Mem_Read_M
//  Mem_Size_M      in   2       access size: 00 byte, 01 half, 10 word; 11 treated as word
//  Mem_Unsigned_M  in   1       1 = zero-extend load, 0 = sign-extend load
//  ALU_Result_M    in   32      byte address of the access
//  Write_Data_M    in   32      store data, right-justified
//  Read_Data_M     out  32      extended load result, registered
//  Stall_M         out  1       freeze the pipeline while high
//  Misalign_M      out  1       one-cycle misaligned-access flag (MISALIGN_TRAP_EN only)
//  bmem_req        out  1       byte transfer request
//  bmem_we         out  1       1 = write byte, 0 = read byte
//  bmem_addr       out  ADDR_W  byte address
//  bmem_wdata      out  8       write byte
//  bmem_rdata      in   8       read byte; valid when bmem_ack = 1
//  bmem_ack        in   1       transfer complete; may be high in the same cycle as bmem_req
// BEHAVIOUR
//  - Reset (async): state IDLE, byte index 0; Read_Data_M, Stall_M, Misalign_M, bmem_* all 0.
//  - States:
//    IDLE: on (Mem_Read_M | Mem_Write_M), latch addr, data, size, unsigned and dir;
//      set N = 1/2/4; go to ACCESS.
//    ACCESS: bmem_req = 1; bmem_addr = addr[ADDR_W-1:0] + idx (wraps mod 2^ADDR_W).
//      On ack: idx++; after the ack for idx == N-1 go to DONE.
//    DONE: one cycle, Stall_M = 0; return to IDLE unconditionally.
//  - Stall_M = (IDLE & request) | ACCESS, combinational.
//    Zero-wait word access stalls 5 cycles; N-byte access with W wait cycles per byte
//    stalls N*(W+1)+1 cycles.
//  - Big-endian byte order: idx 0 is the most significant byte of the sized datum.
//    Store byte k: word -> W[31-8k -:8]; half -> W[15-8k -:8]; byte -> W[7:0].
//  - Load assembly: asm <= {asm[23:0], bmem_rdata} on each ack.
//    On the final ack, Read_Data_M <= asm extended by size and unsigned.
//    Read_Data_M holds between loads; stores never change it.
//  - bmem_addr, bmem_we and bmem_wdata stay stable while req is high and ack is low.
//    req drops in the cycle after the final ack.
//  - Request inputs are ignored outside IDLE; the pipeline holds them stable while stalled.
//  - Reset mid-access aborts the access: req drops at once. A partial store leaves the
//    already-written bytes in memory. The next access starts at idx 0.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    - A half at an odd address, or a word with addr[1:0] != 0, issues no bmem_req.
//    - IDLE goes straight to DONE; Misalign_M = 1 for that DONE cycle.
//    - Read_Data_M is unchanged; the stall lasts 1 cycle.
//  MISALIGN_TRAP_EN undefined:
//    - Misalign_M is tied 0.
//    - Unaligned accesses proceed byte by byte at addr..addr+N-1.
// STRUCTURE
//  - Package mips_mem_pkg: MEM_SIZE_B/H/W encodings, the lsu_state_t enum
//    (IDLE/ACCESS/DONE), and the byte-count function size_to_n().
//  - Sub-module load_extend (combinational): size/unsigned sign or zero extension of the
//    assembled word. FSM, counter and byte select stay in this module.
// TESTING
//  1. Reset: hold rst_n=0 with random inputs -> every output 0. Deassert -> IDLE, Stall_M=0.
//  2. sw 0xDEADBEEF @0x10, zero-wait ack:
//     -> writes DE,AD,BE,EF to 0x10..0x13 in order; Stall_M high 5 cycles.
//     Then lw @0x10 -> Read_Data_M = 0xDEADBEEF.
//  3. lb @0x12 -> 0xFFFFFFBE; lbu @0x12 -> 0x000000BE;
//     lh @0x12 -> 0xFFFFBEEF; lhu @0x12 -> 0x0000BEEF.
//  4. sh 0x1234 @0x20 with ack delayed 3 cycles per byte:
//     -> addr, we, wdata held stable; Stall_M high 9 cycles; bytes 12,34 written.
//  5. Assert rst_n=0 after the 2nd ack of a lw:
//     -> req drops asynchronously; Read_Data_M = 0; the next lw starts from byte 0.
//  6. lw @0x11 (and a word at @0x3FE for wrap):
//     - Macro on: Misalign_M pulses, no req.
//     - Macro off: reads 0x11..0x14; the word at 0x3FE wraps to 0x3FE,0x3FF,0x000,0x001.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings, FSM states and helpers for the MEM-stage byte-serial access unit.
package mips_mem_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } lsu_state_t;

    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: size_to_n = 3'd1;
            MEM_SIZE_H: size_to_n = 3'd2;
            default:    size_to_n = 3'd4;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            MEM_SIZE_B: is_misaligned = 1'b0;
            MEM_SIZE_H: is_misaligned = addr[0];
            default:    is_misaligned = (addr != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of the assembled big-endian load word by access size.
module load_extend
    import mips_mem_pkg::*;
(
    input  logic [31:0] asm_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic sb, sh;

    assign sb = ~unsigned_i & asm_i[7];
    assign sh = ~unsigned_i & asm_i[15];

    always_comb begin
        data_o = asm_i;
        case (size_i)
            MEM_SIZE_B: data_o = {{24{sb}}, asm_i[7:0]};
            MEM_SIZE_H: data_o = {{16{sh}}, asm_i[15:0]};
            default:    data_o = asm_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: splits loads/stores into big-endian byte transfers on bmem_*.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of issuing transfers.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Mem_Read_M,
    input  logic              Mem_Write_M,
    input  logic [1:0]        Mem_Size_M,
    input  logic              Mem_Unsigned_M,
    input  logic [31:0]       ALU_Result_M,
    input  logic [31:0]       Write_Data_M,
    output logic [31:0]       Read_Data_M,
    output logic              Stall_M,
    output logic              Misalign_M,
    output logic              bmem_req,
    output logic              bmem_we,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic [7:0]        bmem_wdata,
    input  logic [7:0]        bmem_rdata,
    input  logic              bmem_ack
);

    lsu_state_t        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mis_q, mis_d;

    logic [2:0]  n_q;
    logic [2:0]  sh_q;
    logic        last;
    logic        acc;
    logic        req_in;
    logic [31:0] asm_nxt;
    logic [31:0] ext;
    logic        unused_hi;

    assign unused_hi = ^ALU_Result_M[31:ADDR_W];

    assign n_q     = size_to_n(size_q);
    assign last    = ({1'b0, idx_q} == n_q - 3'd1);
    assign sh_q    = n_q - 3'd1 - {1'b0, idx_q};
    assign asm_nxt = {asm_q[23:0], bmem_rdata};
    assign acc     = (state_q == ACCESS);
    assign req_in  = Mem_Read_M | Mem_Write_M;

    load_extend u_ext (
        .asm_i      (asm_nxt),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        size_d  = size_q;
        uns_d   = uns_q;
        we_d    = we_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_in) begin
                    addr_d  = ALU_Result_M[ADDR_W-1:0];
                    wdat_d  = Write_Data_M;
                    size_d  = Mem_Size_M;
                    uns_d   = Mem_Unsigned_M;
                    we_d    = Mem_Write_M;
                    idx_d   = 2'd0;
                    asm_d   = '0;
                    state_d = ACCESS;
`ifdef MISALIGN_TRAP_EN
                    if (is_misaligned(Mem_Size_M, ALU_Result_M[1:0])) begin
                        state_d = DONE;
                        mis_d   = 1'b1;
                    end
`endif
                end
            end
            ACCESS: begin
                if (bmem_ack) begin
                    idx_d = idx_q + 2'd1;
                    asm_d = asm_nxt;
                    if (last) begin
                        idx_d   = 2'd0;
                        state_d = DONE;
                        if (!we_q) rdata_d = ext;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            asm_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Byte k of an N-byte datum sits (N-1-k) bytes up from bit 0.
    assign bmem_req    = acc;
    assign bmem_we     = acc & we_q;
    assign bmem_addr   = acc ? addr_q + ADDR_W'(idx_q) : '0;
    assign bmem_wdata  = (acc & we_q) ? 8'(wdat_q >> {sh_q, 3'b000}) : 8'h00;
    assign Read_Data_M = rdata_q;
    assign Stall_M     = rst_n & (((state_q == IDLE) & req_in) | acc);

`ifdef MISALIGN_TRAP_EN
    assign Misalign_M = mis_q;
`else
    logic unused_mis;
    assign unused_mis = mis_q;
    assign Misalign_M = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte memory responder and wait-state control.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd = 1'b0, wr = 1'b0, un = 1'b0;
    logic [1:0]  sz = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata_o;
    logic        stall, mis, req, we, ack;
    logic [9:0]  baddr;
    logic [7:0]  bwd, brd;

    logic [7:0]  mem [0:1023];
    int          waits = 0;
    int          cnt = 0;
    logic [9:0]  la[$];
    logic [7:0]  ld[$];
    int          errors = 0;
    int          checks = 0;

    logic        hv = 1'b0;
    logic [18:0] hsave;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(10)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Mem_Read_M     (rd),
        .Mem_Write_M    (wr),
        .Mem_Size_M     (sz),
        .Mem_Unsigned_M (un),
        .ALU_Result_M   (addr),
        .Write_Data_M   (wdata),
        .Read_Data_M    (rdata_o),
        .Stall_M        (stall),
        .Misalign_M     (mis),
        .bmem_req       (req),
        .bmem_we        (we),
        .bmem_addr      (baddr),
        .bmem_wdata     (bwd),
        .bmem_rdata     (brd),
        .bmem_ack       (ack)
    );

    assign ack = req && (cnt == waits);
    assign brd = mem[baddr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 0;
            hv = 1'b0;
        end else if (req) begin
            if (hv) chk("hold", {13'd0, we, baddr, bwd}, {13'd0, hsave});
            if (ack) begin
                la.push_back(baddr);
                ld.push_back(we ? bwd : brd);
                if (we) mem[baddr] <= bwd;
                cnt <= 0;
                hv = 1'b0;
            end else begin
                cnt <= cnt + 1;
                hv = 1'b1;
                hsave = {we, baddr, bwd};
            end
        end
    end

    task automatic access(input logic r, input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input int ws,
                          output int st);
        @(posedge clk);
        #1;
        la.delete();
        ld.delete();
        waits = ws;
        rd = r; wr = w; sz = s; un = u; addr = a; wdata = d;
        st = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!stall) break;
            st++;
            @(posedge clk);
        end
        if (st >= 200) chk("timeout", 32'd1, 32'd0);
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic chk_log(input string tag, input logic [9:0] a0, input logic [31:0] bytes,
                           input int n);
        chk({tag, "_n"}, la.size(), n);
        for (int i = 0; i < n && i < la.size(); i++) begin
            chk({tag, "_a"}, {22'd0, la[i]}, {22'd0, 10'(a0 + 10'(i))});
            chk({tag, "_d"}, {24'd0, ld[i]}, {24'd0, 8'(bytes >> (8 * (n - 1 - i)))});
        end
    endtask

    int st;

    initial begin
        rd = 1'($urandom); wr = 1'($urandom); sz = 2'($urandom); un = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_ctl", {27'd0, stall, mis, req, we, 1'b0}, 0);
        chk("rst_bus", {14'd0, baddr, bwd}, 0);
        rd = 0; wr = 0; sz = 0; un = 0; addr = 0; wdata = 0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_stall", {31'd0, stall}, 0);

        access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, st);
        chk("sw_stall", st, 5);
        chk_log("sw", 10'h10, 32'hDEADBEEF, 4);
        access(1, 0, 2'b10, 0, 32'h10, 0, 0, st);
        chk("lw", rdata_o, 32'hDEADBEEF);
        chk("lw_stall", st, 5);
        chk("lw_mis", {31'd0, mis}, 0);

        access(1, 0, 2'b00, 0, 32'h12, 0, 0, st);
        chk("lb", rdata_o, 32'hFFFFFFBE);
        chk("lb_stall", st, 2);
        access(1, 0, 2'b00, 1, 32'h12, 0, 0, st);
        chk("lbu", rdata_o, 32'h000000BE);
        access(1, 0, 2'b01, 0, 32'h12, 0, 0, st);
        chk("lh", rdata_o, 32'hFFFFBEEF);
        access(1, 0, 2'b01, 1, 32'h12, 0, 0, st);
        chk("lhu", rdata_o, 32'h0000BEEF);

        access(0, 1, 2'b01, 0, 32'h20, 32'hFFFF1234, 3, st);
        chk("sh_stall", st, 9);
        chk_log("sh", 10'h20, 32'h1234, 2);
        chk("sh_keep", rdata_o, 32'h0000BEEF);
        access(0, 1, 2'b00, 0, 32'h14, 32'hAAAABB77, 1, st);
        chk("sb_stall", st, 3);
        chk_log("sb", 10'h14, 32'h77, 1);
        access(1, 0, 2'b11, 0, 32'h20, 0, 2, st);
        chk("lw11", rdata_o, 32'h12340000);

        @(posedge clk);
        #1;
        la.delete();
        ld.delete();
        waits = 0;
        rd = 1; sz = 2'b10; un = 0; addr = 32'h10;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (la.size() >= 2) break;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_req", {31'd0, req}, 0);
        chk("abort_rdata", rdata_o, 0);
        chk("abort_acks", la.size(), 2);
        @(negedge clk);
        rd = 0;
        @(negedge clk);
        rst_n = 1'b1;
        access(1, 0, 2'b10, 0, 32'h10, 0, 0, st);
        chk("relw", rdata_o, 32'hDEADBEEF);
        chk_log("relw", 10'h10, 32'hDEADBEEF, 4);

`ifdef MISALIGN_TRAP_EN
        access(1, 0, 2'b10, 0, 32'h11, 0, 0, st);
        chk("mis_flag", {31'd0, mis}, 1);
        chk("mis_stall", st, 1);
        chk("mis_nreq", la.size(), 0);
        chk("mis_rdata", rdata_o, 32'hDEADBEEF);
        access(1, 0, 2'b10, 0, 32'h3FE, 0, 0, st);
        chk("mis2_flag", {31'd0, mis}, 1);
        chk("mis2_nreq", la.size(), 0);
        access(1, 0, 2'b01, 0, 32'h21, 0, 0, st);
        chk("mish_flag", {31'd0, mis}, 1);
        @(negedge clk);
        chk("mis_pulse", {31'd0, mis}, 0);
`else
        access(1, 0, 2'b10, 0, 32'h11, 0, 0, st);
        chk("ua_lw", rdata_o, 32'hADBEEF77);
        chk("ua_mis", {31'd0, mis}, 0);
        chk_log("ua", 10'h11, 32'hADBEEF77, 4);
        access(0, 1, 2'b10, 0, 32'h3FE, 32'hCAFEF00D, 0, st);
        chk_log("wrap_sw", 10'h3FE, 32'hCAFEF00D, 4);
        access(1, 0, 2'b10, 0, 32'h3FE, 0, 1, st);
        chk("wrap_lw", rdata_o, 32'hCAFEF00D);
        chk("wrap_stall", st, 9);
        chk_log("wrap_lw", 10'h3FE, 32'hCAFEF00D, 4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
